design_06_driver: RTL and testbench

// - Initiator side of the mkDesign_06 method interface (start / result / check).
// - Runs N transactions. Each one calls start(a,b), reads result(c), calls check(d), then compares the two returns.
// - Counts mismatches and per-handshake timeouts; reports busy/done status.
// - Sits between a test-sequencer or CPU register block and a Design_06 instance.

---
 rtl/design_06_drv_pkg.sv | 23 ++
 rtl/drv_wait_timer.sv | 39 +++
 rtl/design_06_driver.sv | 186 ++++++++++++++++++
 tb/tb_design_06_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/design_06_drv_pkg.sv
// Shared definitions for the Design_06 initiator (driver).
// Holds the FSM state encoding and the default sizing constants used by
// design_06_driver and its wait timer.
package design_06_drv_pkg;

  localparam int DEF_W       = 10;  // operand / return width
  localparam int DEF_NW      = 8;   // iteration-count width
  localparam int DEF_TIMEOUT = 64;  // max cycles spent waiting on one RDY_*

  // IDLE : waiting for go
  // START: calling start(a,b)
  // RES  : sampling result(c)
  // CHK  : calling check(d) and comparing
  // DONE : one-cycle end-of-run pulse
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RES   = 3'd2,
    CHK   = 3'd3,
    DONE  = 3'd4
  } drv_state_e;

endpackage

// File: rtl/drv_wait_timer.sv
// Per-state handshake wait counter.
// Counts consecutive cycles in which the awaited RDY is low and flags the
// cycle that would be the TIMEOUT-th such cycle, so the FSM can abort in it.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart counting (asserted on every state change)
//   inc        : the awaited RDY is low this cycle
//   expired    : this is the TIMEOUT-th consecutive waiting cycle
module drv_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Counter holds the number of waiting cycles already spent, so the
  // TIMEOUT-th waiting cycle is the one where it reads TIMEOUT-1.
  assign expired = inc && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/design_06_driver.sv
// Initiator for the mkDesign_06 method interface (start / result / check).
// Runs num_iter transactions; each calls start(a,b), samples result(c),
// calls check(d) with the sampled result and compares the two returns.
// Ports:
//   CLK, RST_N              : clock, asynchronous active-low reset
//   go, num_iter, seed_*    : run request and parameters (captured in IDLE)
//   start_st_a/b, EN_start, RDY_start   : start method
//   result_st_c, result, RDY_result     : result method
//   check_st_d, EN_check, check, RDY_check : check method
//   busy, done, timeout     : run status (done pulses one cycle)
//   err_count               : mismatches in the last run, saturating
//   last_result, last_check : most recent method returns
module design_06_driver
  import design_06_drv_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int NW      = DEF_NW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          go,
  input  logic [NW-1:0] num_iter,
  input  logic [W-1:0]  seed_a,
  input  logic [W-1:0]  seed_b,
  output logic [W-1:0]  start_st_a,
  output logic [W-1:0]  start_st_b,
  output logic          EN_start,
  input  logic          RDY_start,
  output logic [W-1:0]  result_st_c,
  input  logic [W-1:0]  result,
  input  logic          RDY_result,
  output logic [W-1:0]  check_st_d,
  output logic          EN_check,
  input  logic [W-1:0]  check,
  input  logic          RDY_check,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [NW-1:0] err_count,
  output logic [W-1:0]  last_result,
  output logic [W-1:0]  last_check
);

  drv_state_e    state_q, state_n;
  logic [NW-1:0] iter_q;
  logic [NW-1:0] num_iter_q;
  logic [W-1:0]  seed_a_q, seed_b_q;
  logic [NW-1:0] err_q;
  logic          timeout_q;
  logic [W-1:0]  last_result_q, last_check_q;

  logic          accept_go;
  logic          fire_start, take_result, fire_check;
  logic          last_iter;
  logic [W-1:0]  iter_w;
  logic          wait_inc, wait_clear, wait_expired;

  // Iteration index resized to the argument width (wraps when NW > W).
  assign iter_w = W'(iter_q);

  assign accept_go   = (state_q == IDLE)  && go;
  assign fire_start  = (state_q == START) && RDY_start;
  assign take_result = (state_q == RES)   && RDY_result;
  assign fire_check  = (state_q == CHK)   && RDY_check;
  assign last_iter   = (iter_q == num_iter_q - 1'b1);

  // Waiting means sitting in a handshake state with its RDY low.
  assign wait_inc = ((state_q == START) && !RDY_start)  ||
                    ((state_q == RES)   && !RDY_result) ||
                    ((state_q == CHK)   && !RDY_check);
  assign wait_clear = (state_n != state_q);

  drv_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear   (wait_clear),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // --------------------------------------------------------------- next state
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_n = (num_iter == '0) ? DONE : START;
      end
      START: begin
        if (RDY_start)         state_n = RES;
        else if (wait_expired) state_n = DONE;
      end
      RES: begin
        if (RDY_result)        state_n = CHK;
        else if (wait_expired) state_n = DONE;
      end
      CHK: begin
        if (RDY_check)         state_n = last_iter ? DONE : START;
        else if (wait_expired) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      iter_q        <= '0;
      num_iter_q    <= '0;
      seed_a_q      <= '0;
      seed_b_q      <= '0;
      err_q         <= '0;
      timeout_q     <= 1'b0;
      last_result_q <= '0;
      last_check_q  <= '0;
    end else begin
      if (accept_go) begin
        num_iter_q <= num_iter;
        seed_a_q   <= seed_a;
        seed_b_q   <= seed_b;
        err_q      <= '0;
        timeout_q  <= 1'b0;
        iter_q     <= '0;
      end
      if (take_result) begin
        last_result_q <= result;
      end
      if (fire_check) begin
        last_check_q <= check;
        if ((check != last_result_q) && (err_q != '1)) begin
          err_q <= err_q + 1'b1;
        end
        // iter stays on the final index so the last arguments remain traceable.
        if (!last_iter) begin
          iter_q <= iter_q + 1'b1;
        end
      end
      if (wait_expired) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  // Method enables are gated by RDY combinationally so a method can never be
  // called while its target is not ready, and they drop with reset at once.
  // Argument buses are zero outside the state that uses them.
  always_comb begin
    EN_start    = fire_start;
    EN_check    = fire_check;
    start_st_a  = '0;
    start_st_b  = '0;
    result_st_c = '0;
    check_st_d  = '0;
    if (state_q == START) begin
      start_st_a = seed_a_q + iter_w;
      start_st_b = seed_b_q ^ iter_w;
    end
    if (state_q == RES) begin
      result_st_c = iter_w;
    end
    if (state_q == CHK) begin
      check_st_d = last_result_q;
    end
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign timeout     = timeout_q;
  assign err_count   = err_q;
  assign last_result = last_result_q;
  assign last_check  = last_check_q;

endmodule

// File: tb/tb_design_06_driver.sv
// Directed self-checking bench for design_06_driver.
// A small combinational stub plays the Design_06 target: result = c + 0x100,
// check = d, optionally with bit 0 flipped to inject mismatches.
module tb_design_06_driver;

  localparam int W  = 10;
  localparam int NW = 8;

  logic          CLK;
  logic          RST_N;
  logic          go;
  logic [NW-1:0] num_iter;
  logic [W-1:0]  seed_a, seed_b;
  logic [W-1:0]  start_a, start_b;
  logic          EN_start, RDY_start;
  logic [W-1:0]  result_c, result_v;
  logic          RDY_result;
  logic [W-1:0]  check_d, check_v;
  logic          EN_check, RDY_check;
  logic          busy, done, timeout;
  logic [NW-1:0] err_count;
  logic [W-1:0]  last_result, last_check;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitor state (written only by the monitor process).
  int         n_start = 0;
  int         n_check = 0;
  int         en_viol = 0;
  logic [W-1:0] mon_a = '0;
  logic [W-1:0] mon_b = '0;

  // Stub control (written only by the stimulus process).
  int mode     = 0;  // 0: check=d, 1: flip on 3rd check of run, 2: flip always
  int chk_base = 0;
  logic flip;

  design_06_driver dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .go          (go),
    .num_iter    (num_iter),
    .seed_a      (seed_a),
    .seed_b      (seed_b),
    .start_st_a  (start_a),
    .start_st_b  (start_b),
    .EN_start    (EN_start),
    .RDY_start   (RDY_start),
    .result_st_c (result_c),
    .result      (result_v),
    .RDY_result  (RDY_result),
    .check_st_d  (check_d),
    .EN_check    (EN_check),
    .check       (check_v),
    .RDY_check   (RDY_check),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout),
    .err_count   (err_count),
    .last_result (last_result),
    .last_check  (last_check)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign flip     = (mode == 2) || ((mode == 1) && ((n_check - chk_base) == 2));
  assign result_v = result_c + 10'h100;
  assign check_v  = check_d ^ {9'b0, flip};

  always @(posedge CLK) begin
    if (EN_start) begin
      n_start <= n_start + 1;
      mon_a   <= start_a;
      mon_b   <= start_b;
    end
    if (EN_check) n_check <= n_check + 1;
    if ((EN_start && !RDY_start) || (EN_check && !RDY_check)) en_viol <= en_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Clocks through a run that go was just raised for; returns the number of
  // edges until done is seen (first edge accepts go), or -1 past the limit.
  task automatic wait_done(input int limit, input bit hold_go, output int n);
    n = 0;
    do begin
      tick();
      n++;
      if (!hold_go) go = 1'b0;
    end while (!done && n < limit);
    if (!done) n = -1;
  endtask

  int n, base_s, base_c;

  initial begin
    RST_N = 1'b0; go = 1'b0; num_iter = '0; seed_a = '0; seed_b = '0;
    RDY_start = 1'b1; RDY_result = 1'b1; RDY_check = 1'b1;
    repeat (2) tick();

    // Reset state (RDY high so EN gating on state is exercised).
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en_start", EN_start, 0);
    check("rst_en_check", EN_check, 0);
    check("rst_start_a", start_a, 0);
    check("rst_result_c", result_c, 0);
    check("rst_check_d", check_d, 0);
    check("rst_err", err_count, 0);
    check("rst_timeout", timeout, 0);
    check("rst_last_result", last_result, 0);
    RST_N = 1'b1;
    tick();

    // T1: single transaction, all ready.
    num_iter = 8'd1; seed_a = 10'h005; seed_b = 10'h00A; mode = 0;
    go = 1'b1; tick(); go = 1'b0;
    check("t1_en_start", EN_start, 1);
    check("t1_a", start_a, 10'h005);
    check("t1_b", start_b, 10'h00A);
    check("t1_busy", busy, 1);
    tick();
    check("t1_result_c", result_c, 0);
    check("t1_en_start_off", EN_start, 0);
    tick();
    check("t1_en_check", EN_check, 1);
    check("t1_check_d", check_d, 10'h100);
    tick();
    check("t1_done_cycle4", done, 1);
    check("t1_err", err_count, 0);
    check("t1_last_result", last_result, 10'h100);
    check("t1_last_check", last_check, 10'h100);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_idle", busy, 0);

    // T2: four transactions, mismatch injected on iter 2, seed_a wraps.
    num_iter = 8'd4; seed_a = 10'h3FE; seed_b = 10'h0F0; mode = 1;
    chk_base = n_check; base_s = n_start;
    go = 1'b1; wait_done(50, 1'b0, n);
    check("t2_latency", n, 13);
    check("t2_err", err_count, 1);
    check("t2_last_result", last_result, 10'h103);
    check("t2_last_check", last_check, 10'h103);
    check("t2_a_wrap", mon_a, 10'h001);
    check("t2_b", mon_b, 10'h0F3);
    check("t2_starts", n_start - base_s, 4);
    tick(); mode = 0;

    // T3: start never ready -> timeout after 64 waiting cycles.
    RDY_start = 1'b0; num_iter = 8'd2; base_s = n_start;
    go = 1'b1; wait_done(100, 1'b0, n);
    check("t3_latency", n, 65);
    check("t3_timeout", timeout, 1);
    check("t3_no_en_start", n_start - base_s, 0);
    check("t3_err", err_count, 0);
    tick();
    check("t3_done_pulse", done, 0);
    check("t3_idle", busy, 0);
    check("t3_timeout_sticky", timeout, 1);
    RDY_start = 1'b1;

    // T4: check not ready for 5 cycles, then ready.
    RDY_check = 1'b0; num_iter = 8'd1; seed_a = 10'h010; seed_b = 10'h020;
    go = 1'b1; tick(); go = 1'b0;
    check("t4_timeout_cleared", timeout, 0);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_en_check_held", EN_check, 0);
      check("t4_not_done", done, 0);
      tick();
    end
    RDY_check = 1'b1; #1;
    check("t4_en_check", EN_check, 1);
    check("t4_check_d", check_d, 10'h100);
    tick();
    check("t4_done", done, 1);
    check("t4_timeout", timeout, 0);
    check("t4_err", err_count, 0);
    tick();

    // T5: zero iterations.
    num_iter = 8'd0; base_s = n_start; base_c = n_check;
    go = 1'b1; tick(); go = 1'b0;
    check("t5_done", done, 1);
    check("t5_busy", busy, 1);
    check("t5_en_start", EN_start, 0);
    tick();
    check("t5_done_pulse", done, 0);
    check("t5_idle", busy, 0);
    check("t5_no_calls", (n_start - base_s) + (n_check - base_c), 0);

    // T6: go held during run, reset asserted mid-RES.
    num_iter = 8'd2; seed_a = 10'h100; seed_b = 10'h055;
    go = 1'b1;
    tick(); tick(); tick(); tick();
    check("t6_go_ignored_en", EN_start, 1);
    check("t6_go_ignored_a", start_a, 10'h101);
    check("t6_b", start_b, 10'h054);
    RDY_result = 1'b0;
    tick(); tick();
    check("t6_res_c", result_c, 1);
    check("t6_res_busy", busy, 1);
    check("t6_res_last_result", last_result, 10'h100);
    #2; RST_N = 1'b0; #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_result_c", result_c, 0);
    check("t6_rst_last_result", last_result, 0);
    check("t6_rst_last_check", last_check, 0);
    go = 1'b0; RDY_result = 1'b1;
    tick();
    RST_N = 1'b1;
    tick();
    check("t6_post_idle", busy, 0);
    num_iter = 8'd1; seed_a = 10'h007; seed_b = 10'h000;
    go = 1'b1; wait_done(50, 1'b0, n);
    check("t6_rerun_latency", n, 4);
    check("t6_rerun_a", mon_a, 10'h007);
    check("t6_rerun_err", err_count, 0);
    check("t6_rerun_last_result", last_result, 10'h100);
    tick();

    // T7: maximum run length, every check mismatching.
    num_iter = 8'hFF; seed_a = 10'h000; seed_b = 10'h000; mode = 2;
    base_s = n_start;
    go = 1'b1; wait_done(1000, 1'b0, n);
    check("t7_latency", n, 766);
    check("t7_err", err_count, 8'hFF);
    check("t7_last_result", last_result, 10'h1FE);
    check("t7_last_check", last_check, 10'h1FF);
    check("t7_last_a", mon_a, 10'h0FE);
    check("t7_starts", n_start - base_s, 255);
    tick(); mode = 0;

    check("en_without_rdy", en_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
